// File: rtl/rv_pkg.sv
// Shared RV32I definitions: ALU opcodes, writeback selects, branch funct3 codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rv;

   localparam int XLEN = 32;

   typedef logic [4:0] regaddr_t;

   typedef enum logic [3:0] {
      ALU_ADD   = 4'd0,
      ALU_SUB   = 4'd1,
      ALU_SLL   = 4'd2,
      ALU_SLT   = 4'd3,
      ALU_SLTU  = 4'd4,
      ALU_XOR   = 4'd5,
      ALU_SRL   = 4'd6,
      ALU_SRA   = 4'd7,
      ALU_OR    = 4'd8,
      ALU_AND   = 4'd9,
      ALU_PASSB = 4'd10
   } aluop_t;

   typedef enum logic [1:0] {
      WSEL_ALU = 2'd0,
      WSEL_MEM = 2'd1,
      WSEL_PC4 = 2'd2,
      WSEL_CSR = 2'd3
   } wsel_t;

   localparam logic [2:0] BR_EQ  = 3'b000;
   localparam logic [2:0] BR_NE  = 3'b001;
   localparam logic [2:0] BR_LT  = 3'b100;
   localparam logic [2:0] BR_GE  = 3'b101;
   localparam logic [2:0] BR_LTU = 3'b110;
   localparam logic [2:0] BR_GEU = 3'b111;

endpackage

// File: rtl/core_alu.sv
// Combinational integer ALU (a, b, op -> result), reusable by other issue paths.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; result follows inputs.
// Ports: a, b operands; op ALU operation; result wraps modulo 2^XLEN.
module core_alu
   import rv::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  aluop_t          op,
   output logic [XLEN-1:0] result
);

   logic [4:0] shamt;
   assign shamt = b[4:0];

   always_comb begin
      result = '0;
      case (op)
         ALU_ADD:   result = a + b;
         ALU_SUB:   result = a - b;
         ALU_SLL:   result = a << shamt;
         ALU_SLT:   result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
         ALU_SLTU:  result = {{(XLEN-1){1'b0}}, (a < b)};
         ALU_XOR:   result = a ^ b;
         ALU_SRL:   result = a >> shamt;
         ALU_SRA:   result = $unsigned($signed(a) >>> shamt);
         ALU_OR:    result = a | b;
         ALU_AND:   result = a & b;
         ALU_PASSB: result = b;
         default:   result = '0;
      endcase
   end

endmodule

// File: rtl/core_execute.sv
// RV32I execute stage: ALU, branch/jump resolution, writeback preselect into the m register.
// Latency: 1 cycle from x acceptance to m_valid; redirect is combinational in the accept cycle.
// Backpressure: x_ready = ~m_valid | m_ready; m payload held stable while m_valid & ~m_ready.
// Ports: x_* decoded instruction in, m_* pipeline register out, redirect_* to fetch, fwd_* forwarding tap.
module core_execute
   import rv::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            x_valid,
   output logic            x_ready,
   input  logic [XLEN-1:0] x_pc,
   input  logic [XLEN-1:0] x_imm,
   input  logic [XLEN-1:0] x_rs1,
   input  logic [XLEN-1:0] x_rs2,
   input  logic [XLEN-1:0] x_csr_value,
   input  logic [4:0]      x_rd,
   input  logic            x_reg_wen,
   input  logic [1:0]      x_reg_wsel,
   input  logic [3:0]      x_aluop,
   input  logic            x_asel,
   input  logic            x_bsel,
   input  logic [2:0]      x_mem_type,
   input  logic            x_mem_ren,
   input  logic            x_mem_wen,
   input  logic            x_is_jump,
   input  logic            x_is_branch,
   input  logic [2:0]      x_branch_cond,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   output logic            m_valid,
   input  logic            m_ready,
   output logic [XLEN-1:0] m_pc,
   output logic [XLEN-1:0] m_result,
   output logic [XLEN-1:0] m_addr,
   output logic [XLEN-1:0] m_wdata,
   output logic [4:0]      m_rd,
   output logic            m_reg_wen,
   output logic            m_mem_ren,
   output logic            m_mem_wen,
   output logic [1:0]      m_reg_wsel,
   output logic [2:0]      m_mem_type,
   output logic            fwd_en,
   output logic [4:0]      fwd_rd,
   output logic [XLEN-1:0] fwd_value
);

   logic [XLEN-1:0] op_a, op_b, alu_result, br_target, wb_value;
   logic            acc, br_cond, taken;

   assign x_ready = ~m_valid | m_ready;
   assign acc     = x_valid & x_ready & ~flush;

   assign op_a = x_asel ? x_pc  : x_rs1;
   assign op_b = x_bsel ? x_imm : x_rs2;

   core_alu #(.XLEN(XLEN)) u_alu (
      .a      (op_a),
      .b      (op_b),
      .op     (aluop_t'(x_aluop)),
      .result (alu_result)
   );

   // Branches compare the raw register operands; the ALU may be busy with something else.
   always_comb begin
      br_cond = 1'b0;
      case (x_branch_cond)
         BR_EQ:   br_cond = (x_rs1 == x_rs2);
         BR_NE:   br_cond = (x_rs1 != x_rs2);
         BR_LT:   br_cond = ($signed(x_rs1) <  $signed(x_rs2));
         BR_GE:   br_cond = ($signed(x_rs1) >= $signed(x_rs2));
         BR_LTU:  br_cond = (x_rs1 <  x_rs2);
         BR_GEU:  br_cond = (x_rs1 >= x_rs2);
         default: br_cond = 1'b0;
      endcase
   end

   assign taken     = x_is_jump | (x_is_branch & br_cond);
   assign br_target = x_pc + x_imm;

   // Jump targets come from the ALU (pc+imm or rs1+imm) with bit 0 cleared, covering JAL and JALR.
   // Misaligned bit 1 is passed through; fetch raises the trap.
   assign redirect_pc    = x_is_jump ? {alu_result[XLEN-1:1], 1'b0} : br_target;
   assign redirect_valid = acc & taken & ~rst;

   // MEM keeps the address here; the memory stage substitutes the load data.
   always_comb begin
      wb_value = alu_result;
      case (wsel_t'(x_reg_wsel))
         WSEL_ALU: wb_value = alu_result;
         WSEL_MEM: wb_value = alu_result;
         WSEL_PC4: wb_value = x_pc + XLEN'(4);
         WSEL_CSR: wb_value = x_csr_value;
         default:  wb_value = alu_result;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_valid    <= 1'b0;
         m_pc       <= '0;
         m_result   <= '0;
         m_addr     <= '0;
         m_wdata    <= '0;
         m_rd       <= '0;
         m_reg_wen  <= 1'b0;
         m_mem_ren  <= 1'b0;
         m_mem_wen  <= 1'b0;
         m_reg_wsel <= '0;
         m_mem_type <= '0;
      end else if (acc) begin
         m_valid    <= 1'b1;
         m_pc       <= x_pc;
         m_result   <= wb_value;
         m_addr     <= alu_result;
         m_wdata    <= x_rs2;
         m_rd       <= x_rd;
         m_reg_wen  <= x_reg_wen;
         m_mem_ren  <= x_mem_ren;
         m_mem_wen  <= x_mem_wen;
         m_reg_wsel <= x_reg_wsel;
         m_mem_type <= x_mem_type;
      end else if (m_ready) begin
         m_valid <= 1'b0;
      end
   end

   // Loads are not forwardable from here: their value only exists after the memory stage.
   assign fwd_en    = m_valid & m_reg_wen & (m_rd != 5'd0) & (m_reg_wsel != WSEL_MEM);
   assign fwd_rd    = m_rd;
   assign fwd_value = m_result;

endmodule

// File: tb/tb_core_execute.sv
// Self-checking bench for core_execute: directed scenarios plus randomized traffic vs a behavioural model.
// Latency: n/a.
// Backpressure: m_ready driven randomly and in directed stall sequences.
module tb_core_execute;
   import rv::*;

   logic        clk, rst, flush, x_valid, x_ready;
   logic [31:0] x_pc, x_imm, x_rs1, x_rs2, x_csr_value;
   logic [4:0]  x_rd;
   logic        x_reg_wen, x_asel, x_bsel, x_mem_ren, x_mem_wen, x_is_jump, x_is_branch;
   logic [1:0]  x_reg_wsel;
   logic [3:0]  x_aluop;
   logic [2:0]  x_mem_type, x_branch_cond;
   logic        redirect_valid, m_valid, m_ready;
   logic [31:0] redirect_pc, m_pc, m_result, m_addr, m_wdata, fwd_value;
   logic [4:0]  m_rd, fwd_rd;
   logic        m_reg_wen, m_mem_ren, m_mem_wen, fwd_en;
   logic [1:0]  m_reg_wsel;
   logic [2:0]  m_mem_type;

   core_execute dut (
      .clk(clk), .rst(rst), .flush(flush), .x_valid(x_valid), .x_ready(x_ready),
      .x_pc(x_pc), .x_imm(x_imm), .x_rs1(x_rs1), .x_rs2(x_rs2), .x_csr_value(x_csr_value),
      .x_rd(x_rd), .x_reg_wen(x_reg_wen), .x_reg_wsel(x_reg_wsel), .x_aluop(x_aluop),
      .x_asel(x_asel), .x_bsel(x_bsel), .x_mem_type(x_mem_type), .x_mem_ren(x_mem_ren),
      .x_mem_wen(x_mem_wen), .x_is_jump(x_is_jump), .x_is_branch(x_is_branch),
      .x_branch_cond(x_branch_cond), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .m_valid(m_valid), .m_ready(m_ready), .m_pc(m_pc), .m_result(m_result), .m_addr(m_addr),
      .m_wdata(m_wdata), .m_rd(m_rd), .m_reg_wen(m_reg_wen), .m_mem_ren(m_mem_ren),
      .m_mem_wen(m_mem_wen), .m_reg_wsel(m_reg_wsel), .m_mem_type(m_mem_type),
      .fwd_en(fwd_en), .fwd_rd(fwd_rd), .fwd_value(fwd_value)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic [31:0] pc, result, addr, wdata;
      logic [4:0]  rd;
      logic        reg_wen, mem_ren, mem_wen;
      logic [1:0]  wsel;
      logic [2:0]  mtype;
   } mreg_t;

   mreg_t       exp_m;
   int          n_checks = 0;
   int          n_fail   = 0;
   logic        obs_rv, obs_xr;
   logic [31:0] obs_rpc;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // Architectural meaning of each instruction, straight from the ISA rules.
   function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
      int unsigned sh;
      sh = b % 32;
      case (op)
         0:  return a + b;
         1:  return a - b;
         2:  return a << sh;
         3:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
         4:  return (a < b) ? 32'd1 : 32'd0;
         5:  return a ^ b;
         6:  return a >> sh;
         7:  return 32'(int'(a) >>> sh);
         8:  return a | b;
         9:  return a & b;
         10: return b;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic ref_cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      case (f3)
         3'd0: return a == b;
         3'd1: return a != b;
         3'd4: return int'(a) < int'(b);
         3'd5: return int'(a) >= int'(b);
         3'd6: return a < b;
         3'd7: return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   function automatic void ref_exec(output mreg_t r, output logic tk, output logic [31:0] tg);
      logic [31:0] alu;
      alu = ref_alu(int'(x_aluop), x_asel ? x_pc : x_rs1, x_bsel ? x_imm : x_rs2);
      r.v = 1'b1;
      r.pc = x_pc;
      r.addr = alu;
      r.wdata = x_rs2;
      r.rd = x_rd;
      r.reg_wen = x_reg_wen;
      r.mem_ren = x_mem_ren;
      r.mem_wen = x_mem_wen;
      r.wsel = x_reg_wsel;
      r.mtype = x_mem_type;
      if (x_reg_wsel == 2'd2)      r.result = x_pc + 32'd4;
      else if (x_reg_wsel == 2'd3) r.result = x_csr_value;
      else                         r.result = alu;
      tk = x_is_jump || (x_is_branch && ref_cond(x_branch_cond, x_rs1, x_rs2));
      tg = x_is_jump ? (alu & 32'hFFFF_FFFE) : (x_pc + x_imm);
   endfunction

   task automatic check_m();
      logic exp_fwd;
      exp_fwd = exp_m.v && exp_m.reg_wen && (exp_m.rd != 0) && (exp_m.wsel != 2'd1);
      check("m_valid", {31'b0, m_valid}, {31'b0, exp_m.v});
      check("fwd_en", {31'b0, fwd_en}, {31'b0, exp_fwd});
      if (exp_m.v) begin
         check("m_pc", m_pc, exp_m.pc);
         check("m_result", m_result, exp_m.result);
         check("m_addr", m_addr, exp_m.addr);
         check("m_wdata", m_wdata, exp_m.wdata);
         check("m_ctrl", {17'b0, m_rd, m_reg_wen, m_mem_ren, m_mem_wen, m_reg_wsel, m_mem_type},
               {17'b0, exp_m.rd, exp_m.reg_wen, exp_m.mem_ren, exp_m.mem_wen, exp_m.wsel, exp_m.mtype});
         check("fwd_value", fwd_value, exp_m.result);
         check("fwd_rd", {27'b0, fwd_rd}, {27'b0, exp_m.rd});
      end
   endtask

   // One clock: inputs already driven; check combinational outputs mid-cycle, then the m register.
   task automatic step();
      mreg_t       nx;
      logic        tk, e_acc, e_xr;
      logic [31:0] tg;
      @(negedge clk);
      ref_exec(nx, tk, tg);
      e_xr  = !exp_m.v || m_ready;
      e_acc = x_valid && e_xr && !flush;
      obs_rv = redirect_valid; obs_rpc = redirect_pc; obs_xr = x_ready;
      check("x_ready", {31'b0, x_ready}, {31'b0, e_xr});
      check("redirect_valid", {31'b0, redirect_valid}, {31'b0, e_acc && tk});
      if (e_acc && tk) check("redirect_pc", redirect_pc, tg);
      @(posedge clk);
      if (e_acc)        exp_m = nx;
      else if (m_ready) exp_m.v = 1'b0;
      #1;
      check_m();
   endtask

   task automatic clear_instr();
      flush = 0; x_valid = 0; x_pc = 0; x_imm = 0; x_rs1 = 0; x_rs2 = 0; x_csr_value = 0;
      x_rd = 0; x_reg_wen = 0; x_reg_wsel = WSEL_ALU; x_aluop = ALU_ADD; x_asel = 0; x_bsel = 0;
      x_mem_type = 0; x_mem_ren = 0; x_mem_wen = 0; x_is_jump = 0; x_is_branch = 0; x_branch_cond = 0;
   endtask

   task automatic rand_instr();
      x_valid = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 7) == 0);
      x_pc = $urandom & 32'hFFFF_FFFC;
      x_imm = ($urandom_range(0, 1) != 0) ? $urandom : 32'($signed(12'($urandom)));
      x_rs1 = $urandom;
      x_rs2 = ($urandom_range(0, 2) == 0) ? x_rs1 : $urandom;
      x_csr_value = $urandom;
      x_rd = 5'($urandom);
      x_reg_wen = 1'($urandom);
      x_reg_wsel = 2'($urandom);
      x_aluop = 4'($urandom_range(0, 10));
      x_asel = 1'($urandom); x_bsel = 1'($urandom);
      x_mem_type = 3'($urandom); x_mem_ren = 1'($urandom); x_mem_wen = 1'($urandom);
      x_is_jump = ($urandom_range(0, 5) == 0);
      x_is_branch = !x_is_jump && ($urandom_range(0, 2) == 0);
      x_branch_cond = 3'($urandom);
   endtask

   initial begin
      exp_m = '{default: '0};
      clear_instr();
      m_ready = 1;
      rst = 1;
      #3;
      check("rst_m_valid", {31'b0, m_valid}, 32'd0);
      check("rst_m_result", m_result, 32'd0);
      check("rst_fwd_en", {31'b0, fwd_en}, 32'd0);
      check("rst_redirect", {31'b0, redirect_valid}, 32'd0);
      #9 rst = 0;
      @(posedge clk); #1;

      // ADD 5+7 -> x3
      x_valid = 1; x_rs1 = 5; x_rs2 = 7; x_rd = 3; x_reg_wen = 1; x_aluop = ALU_ADD;
      step();
      check("add_result", m_result, 32'd12);
      check("add_fwd_en", {31'b0, fwd_en}, 32'd1);
      check("add_fwd_rd", {27'b0, fwd_rd}, 32'd3);

      // BEQ taken, then BNE not taken
      clear_instr();
      x_valid = 1; x_rs1 = 32'h10; x_rs2 = 32'h10; x_pc = 32'h100; x_imm = 32'hFFFF_FFF8;
      x_is_branch = 1; x_branch_cond = BR_EQ;
      step();
      check("beq_rv", {31'b0, obs_rv}, 32'd1);
      check("beq_rpc", obs_rpc, 32'h0000_00F8);
      x_branch_cond = BR_NE;
      step();
      check("bne_rv", {31'b0, obs_rv}, 32'd0);

      // JALR: target (0x1001+2)&~1, link pc+4
      clear_instr();
      x_valid = 1; x_rs1 = 32'h1001; x_imm = 2; x_bsel = 1; x_rd = 1; x_reg_wen = 1;
      x_reg_wsel = WSEL_PC4; x_pc = 32'h40; x_is_jump = 1;
      step();
      check("jalr_rpc", obs_rpc, 32'h0000_1002);
      check("jalr_result", m_result, 32'h0000_0044);

      // Backpressure: stall a taken branch two cycles, then release
      clear_instr();
      x_valid = 1; x_rs1 = 1; x_rs2 = 2; x_pc = 32'h200; x_imm = 32'h20;
      x_is_branch = 1; x_branch_cond = BR_LTU; x_rd = 9; x_reg_wen = 1;
      m_ready = 0;
      step();
      check("bp_xready", {31'b0, obs_xr}, 32'd0);
      check("bp_no_redirect", {31'b0, obs_rv}, 32'd0);
      check("bp_hold_result", m_result, 32'h0000_0044);
      step();
      check("bp_hold_result2", m_result, 32'h0000_0044);
      m_ready = 1;
      step();
      check("bp_release_rv", {31'b0, obs_rv}, 32'd1);
      check("bp_release_rpc", obs_rpc, 32'h0000_0220);
      x_valid = 0;
      step();
      check("bp_once_rv", {31'b0, obs_rv}, 32'd0);

      // Flush kills a taken JAL
      clear_instr();
      x_valid = 1; flush = 1; x_asel = 1; x_bsel = 1; x_pc = 32'h300; x_imm = 32'h80; x_is_jump = 1;
      x_rd = 1; x_reg_wen = 1; x_reg_wsel = WSEL_PC4;
      step();
      check("flush_rv", {31'b0, obs_rv}, 32'd0);
      check("flush_mvalid", {31'b0, m_valid}, 32'd0);

      // No forwarding for loads or rd=0
      clear_instr();
      x_valid = 1; x_rd = 5; x_reg_wen = 1; x_reg_wsel = WSEL_MEM; x_mem_ren = 1; x_bsel = 1; x_imm = 4;
      step();
      check("load_fwd_en", {31'b0, fwd_en}, 32'd0);
      x_rd = 0; x_reg_wsel = WSEL_ALU; x_mem_ren = 0;
      step();
      check("rd0_fwd_en", {31'b0, fwd_en}, 32'd0);

      // Asynchronous reset mid-cycle with m_valid=1 and a taken jump offered
      clear_instr();
      x_valid = 1; x_rs1 = 32'h55; x_rd = 4; x_reg_wen = 1; x_is_jump = 1;
      m_ready = 0;
      #2 rst = 1;
      #1;
      check("arst_m_valid", {31'b0, m_valid}, 32'd0);
      check("arst_m_result", m_result, 32'd0);
      check("arst_redirect", {31'b0, redirect_valid}, 32'd0);
      exp_m = '{default: '0};
      x_valid = 0;
      #2 rst = 0;
      @(posedge clk); #1;
      m_ready = 1;

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         rand_instr();
         m_ready = ($urandom_range(0, 3) != 0);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/core_execute.md
Name: core_execute

Overview:
- Execute stage of the in-order RV32I core. Consumer end of the decode→execute (x) interface.
- Takes each decoded, operand-resolved instruction and performs the ALU operation, branch/jump resolution and writeback-value preselection.
- Registers the result into the execute→memory (m) pipeline register under a valid/ready handshake.
- Drives the control-flow redirect back to fetch/decode and exposes the m-register result for forwarding.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- flush  in  1  kill the instruction offered on x this cycle (trap/squash from later stage)
- x_valid  in  1  x payload valid
- x_ready  out  1  execute can accept the x payload
- x_pc, x_imm, x_rs1, x_rs2, x_csr_value  in  32 each  pc, immediate, forwarded operands, CSR read value
- x_rd  in  5  destination register
- x_reg_wen  in  1  writes rd
- x_reg_wsel  in  2  rv::wsel_t {ALU, MEM, PC4, CSR}
- x_aluop  in  4  rv::aluop_t
- x_asel, x_bsel  in  1 each  A = rs1/pc; B = rs2/imm
- x_mem_type  in  3  funct3 load/store size, passed through
- x_mem_ren, x_mem_wen, x_is_jump, x_is_branch  in  1 each
- x_branch_cond  in  3  branch funct3
- redirect_valid  out  1  taken branch/jump accepted this cycle
- redirect_pc  out  32  new fetch pc
- m_valid  out  1  m payload valid
- m_ready  in  1  memory stage accepts
- m_pc, m_result, m_addr, m_wdata  out  32 each  pc, preselected writeback value, ALU result/address, store data
- m_rd  out  5
- m_reg_wen, m_mem_ren, m_mem_wen  out  1 each
- m_reg_wsel  out  2
- m_mem_type  out  3
- fwd_en  out  1  m register holds a forwardable result
- fwd_rd  out  5  rd of that result
- fwd_value  out  32  its value

Behaviour:
- Reset (async, rst=1): m_valid=0; all m_* payload = 0; redirect_valid=0 immediately.
- x_ready = ~m_valid | m_ready. This is combinational and does not depend on x_valid.
- Accept: acc = x_valid & x_ready & ~flush. flush=1 wins over x_valid: nothing latched, no redirect.
- On each clock edge:
  - acc=1: load the m register from the computed values, m_valid<=1.
  - Else if m_ready=1: m_valid<=0.
  - Otherwise hold. The payload must be stable while m_valid=1 and m_ready=0.
- ALU operands: A = asel ? pc : rs1; B = bsel ? imm : rs2.
- ALU ops: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASSB.
  - Shift amount is B[4:0].
  - SLT/SLTU produce 0/1.
  - All arithmetic wraps modulo 2^32.
- Branch condition on rs1 vs rs2 (never on the ALU output):
  - 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU.
  - 010/011 are never taken.
- taken = is_jump | (is_branch & cond).
- Target:
  - Jump: alu_result & ~1. This covers JAL (pc+imm) and JALR ((rs1+imm) with bit 0 cleared).
  - Branch: pc + imm, via a separate adder.
- redirect_valid = acc & taken; redirect_pc = target. Both are combinational, same cycle as acceptance.
  - Asserted exactly once per instruction.
  - While stalled (x_ready=0), redirect is not asserted even if x_valid=1.
- Misaligned targets (bit 1 set) are forwarded unchanged; trap detection belongs to fetch.
- Writeback preselection by reg_wsel:
  - ALU: alu_result. PC4: pc+4. CSR: csr_value.
  - MEM: alu_result, which the memory stage replaces with load data.
- m_addr = alu_result; m_wdata = rs2 (raw; byte lane alignment is done by the memory stage).
- Forwarding: fwd_en = m_valid & m_reg_wen & (m_rd≠0) & (m_reg_wsel≠MEM); fwd_rd = m_rd; fwd_value = m_result.
- Back-to-back: with m_ready held high, one instruction per cycle, latency 1 from x acceptance to m_valid.

Decomposition:
- In the shared rv package: aluop_t and wsel_t enums, branch funct3 constants, regaddr_t.
- Sub-module core_alu: purely combinational (a, b, op → result). It is reusable by a future multi-issue path.
- Branch compare and the m register stay in core_execute.

Test Plan:
- ADD: rs1=5, rs2=7, bsel=0, wsel=ALU, rd=3, m_ready=1 → next cycle m_valid=1, m_result=12, fwd_en=1, fwd_rd=3.
- BEQ: rs1=rs2=0x10, pc=0x100, imm=-8 → redirect_valid=1 in the accept cycle, redirect_pc=0xF8. Same stimulus with BNE → redirect_valid=0.
- JALR: rs1=0x1001, imm=2, rd=1, wsel=PC4, pc=0x40 → redirect_pc=0x1002, m_result=0x44.
- Backpressure: m_ready=0 with m_valid=1 → x_ready=0; a taken branch offered gives no redirect and m_* stays stable. Raise m_ready → accept and redirect on that cycle only.
- flush=1 with x_valid=1 and a taken JAL → no redirect, m_valid stays 0 next cycle.
- Assert rst mid-stream while m_valid=1 → m_valid=0 and m_result=0 asynchronously, before the next clk edge. Load with rd=0 or wsel=MEM → fwd_en=0.
